stage2_bias_act_pool: RTL and testbench
=======================================

STAGE2_BIAS_ACT_POOL -- requirements
Module: stage2_bias_act_pool

Interface
REQ-001 SHALL have parameter ACI_BW, default 24: width of the input CI-accumulated sum.
REQ-002 SHALL have parameter B_BW, default 16: width of the signed bias.
REQ-003 SHALL have parameter O_BW, default 8: width of the signed pooled output.
REQ-004 SHALL have parameter SHIFT, default 8: arithmetic right shift applied for requantisation.
REQ-005 SHALL have parameter IMG_W, default 8: conv output columns; must be even.
REQ-006 SHALL have parameter IMG_H, default 8: conv output rows; must be even.
REQ-007 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-008 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port i_clear, input, 1 bit: synchronous frame abort.
REQ-010 SHALL have port i_bias, input, B_BW bits: signed bias, static during a frame.
REQ-011 SHALL have port i_in_valid, input, 1 bit: i_ci_acc is valid this cycle.
REQ-012 SHALL have port i_ci_acc, input, ACI_BW bits: signed sum, raster order.
REQ-013 SHALL have port o_ot_valid, output, 1 bit: o_ot_pool is valid.
REQ-014 SHALL have port o_ot_pool, output, O_BW bits: signed 2x2 max-pooled activation.
REQ-015 SHALL have port o_frame_done, output, 1 bit: single-cycle pulse on the last pool output of a frame.

Function
REQ-016 SHALL register sum = sext(i_ci_acc) + sext(i_bias) at width max(ACI_BW,B_BW)+1 in the cycle after a valid input (stage A).
REQ-017 SHALL compute act = sum >>> SHIFT (floor), clamp it per REQ-031/032, and register the result (stage B, t+2).
REQ-018 SHALL track column and row counters that advance only on valid samples in stage B; invalid cycles SHALL hold all state (gaps allowed).
REQ-019 SHALL store act into a hold register at even columns; at odd columns hmax = max(hold, act).
REQ-020 SHALL write hmax into a line buffer of IMG_W/2 entries at index col>>1 on even rows.
REQ-021 SHALL, on odd rows at odd columns, register o_ot_pool = max(linebuf[col>>1], hmax) and assert o_ot_valid for one cycle, 3 cycles after the (odd row, odd col) input sample.
REQ-022 SHALL produce exactly (IMG_W/2)*(IMG_H/2) outputs per frame, in raster order.
REQ-023 SHALL wrap the column counter to 0 after IMG_W-1 and increment row; after (IMG_H-1, IMG_W-1) SHALL wrap both to 0 and pulse o_frame_done together with that output.
REQ-024 SHALL, on i_clear, zero the counters, hold register and pipeline valids on the next edge; in-flight samples SHALL be dropped and produce no output.
REQ-025 SHALL give i_clear priority when it coincides with i_in_valid; that sample SHALL be discarded.
REQ-026 SHALL use signed comparison for all max operations.

Reset
REQ-027 SHALL, while reset_n is low, drive o_ot_valid=0, o_ot_pool=0 and o_frame_done=0, and clear the counters, hold register and all pipeline registers.
REQ-028 SHALL leave line buffer contents unreset; they are always written before being read.
REQ-029 SHALL, on reset mid-frame, restart at pixel (0,0) with no residual output.

Configuration
REQ-030 SHALL use the macro ST2_RELU_EN.
REQ-031 With ST2_RELU_EN defined, SHALL clamp act to [0, 2^(O_BW-1)-1] (ReLU plus upper saturation).
REQ-032 Without ST2_RELU_EN, SHALL saturate act to [-2^(O_BW-1), 2^(O_BW-1)-1].

Structure
REQ-033 SHALL take ACI_BW, O_BW and the image dimensions from the shared stage2 defines package; local duplicates SHALL NOT be used.
REQ-034 SHALL implement stages A and B (bias, shift, clamp) as sub-module stage2_act_quant; pooling, counters and line buffer SHALL be in the top module.

Verification
REQ-035 SHALL test: i_ci_acc=1280, bias=0, every cycle for 64 samples -> 16 outputs all 5; o_frame_done with the 16th output.
REQ-036 SHALL test: i_ci_acc=-2560, bias=0 -> output 0 with ST2_RELU_EN, -10 (0xF6) without.
REQ-037 SHALL test: i_ci_acc=100000 -> output 127; i_ci_acc=-100000 without ST2_RELU_EN -> output -128.
REQ-038 SHALL test: window values 256*{1,2,3,4} at (0,0),(0,1),(1,0),(1,1), bias=-256 -> first output 3, o_ot_valid 3 cycles after the (1,1) input.
REQ-039 SHALL test: REQ-038 stream with 2 idle cycles between samples -> identical output values and count.
REQ-040 SHALL test: i_clear at sample 20, then a full frame -> no output from the aborted frame, 16 correct outputs, one o_frame_done.

Source files
------------

// File: rtl/stage2_bias_act_pool_pkg.sv
// Shared stage2 defines: datapath widths, image geometry and sizing helpers.
// Consumers select ReLU clamping with the ST2_RELU_EN macro.
package stage2_bias_act_pool_pkg;

  localparam int ST2_ACI_BW = 24;
  localparam int ST2_B_BW   = 16;
  localparam int ST2_O_BW   = 8;
  localparam int ST2_SHIFT  = 8;
  localparam int ST2_IMG_W  = 8;
  localparam int ST2_IMG_H  = 8;

  // Bias-add width: one guard bit over the wider operand so the sum never wraps.
  function automatic int st2_sum_bw(input int aci_bw, input int b_bw);
    return ((aci_bw > b_bw) ? aci_bw : b_bw) + 1;
  endfunction

endpackage

// File: rtl/stage2_bias_act_pool_if.sv
// Sample-in / pooled-out stream bundle for stage2_bias_act_pool.
interface stage2_bias_act_pool_if
  import stage2_bias_act_pool_pkg::*;
#(
  parameter int ACI_BW = ST2_ACI_BW,
  parameter int O_BW   = ST2_O_BW
);
  logic                     i_in_valid;
  logic signed [ACI_BW-1:0] i_ci_acc;
  logic                     o_ot_valid;
  logic signed [O_BW-1:0]   o_ot_pool;
  logic                     o_frame_done;

  modport master (
    output i_in_valid, i_ci_acc,
    input  o_ot_valid, o_ot_pool, o_frame_done
  );

  modport slave (
    input  i_in_valid, i_ci_acc,
    output o_ot_valid, o_ot_pool, o_frame_done
  );
endinterface

// File: rtl/stage2_bias_act_pool_act_quant.sv
// Stages A/B: bias add, arithmetic-shift requantisation and output clamp.
// ST2_RELU_EN selects a [0, max] clamp instead of symmetric saturation.
module stage2_act_quant
  import stage2_bias_act_pool_pkg::*;
#(
  parameter int ACI_BW = ST2_ACI_BW,
  parameter int B_BW   = ST2_B_BW,
  parameter int O_BW   = ST2_O_BW,
  parameter int SHIFT  = ST2_SHIFT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_clear,
  input  logic signed [B_BW-1:0]   i_bias,
  input  logic                     i_in_valid,
  input  logic signed [ACI_BW-1:0] i_ci_acc,
  output logic                     o_act_valid,
  output logic signed [O_BW-1:0]   o_act
);
  localparam int SW = st2_sum_bw(ACI_BW, B_BW);
  localparam logic signed [SW-1:0] ACT_MAX = SW'((1 << (O_BW - 1)) - 1);
`ifdef ST2_RELU_EN
  localparam logic signed [SW-1:0] ACT_MIN = '0;
`else
  localparam logic signed [SW-1:0] ACT_MIN = SW'(-(1 << (O_BW - 1)));
`endif

  logic                   valid_a;
  logic signed [SW-1:0]   sum_a;
  logic signed [SW-1:0]   act_s;
  logic signed [O_BW-1:0] act_c;

  // Arithmetic shift floors toward minus infinity, then clamp into the output range.
  always_comb begin
    act_s = sum_a >>> SHIFT;
    if (act_s > ACT_MAX)      act_c = ACT_MAX[O_BW-1:0];
    else if (act_s < ACT_MIN) act_c = ACT_MIN[O_BW-1:0];
    else                      act_c = act_s[O_BW-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_a     <= 1'b0;
      sum_a       <= '0;
      o_act_valid <= 1'b0;
      o_act       <= '0;
    end else if (i_clear) begin
      valid_a     <= 1'b0;
      o_act_valid <= 1'b0;
    end else begin
      valid_a     <= i_in_valid;
      o_act_valid <= valid_a;
      if (i_in_valid)
        sum_a <= {{(SW-ACI_BW){i_ci_acc[ACI_BW-1]}}, i_ci_acc}
               + {{(SW-B_BW){i_bias[B_BW-1]}}, i_bias};
      if (valid_a)
        o_act <= act_c;
    end
  end
endmodule

// File: rtl/stage2_bias_act_pool.sv
// Bias/activation followed by 2x2 max-pooling over a raster-order frame.
// ST2_RELU_EN (see stage2_act_quant) selects ReLU clamping.
module stage2_bias_act_pool
  import stage2_bias_act_pool_pkg::*;
#(
  parameter int ACI_BW = ST2_ACI_BW,
  parameter int B_BW   = ST2_B_BW,
  parameter int O_BW   = ST2_O_BW,
  parameter int SHIFT  = ST2_SHIFT,
  parameter int IMG_W  = ST2_IMG_W,
  parameter int IMG_H  = ST2_IMG_H
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_clear,
  input  logic signed [B_BW-1:0] i_bias,
  stage2_bias_act_pool_if.slave  bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PW = IMG_W / 2;
  localparam int LW = (PW > 1) ? $clog2(PW) : 1;

  logic                   act_valid;
  logic signed [O_BW-1:0] act;
  logic signed [O_BW-1:0] hold;
  logic signed [O_BW-1:0] hmax;
  logic signed [O_BW-1:0] lb_rd;
  logic signed [O_BW-1:0] linebuf [PW];
  logic [CW-1:0]          col;
  logic [RW-1:0]          row;
  logic [LW-1:0]          idx;
  logic                   last_col;
  logic                   last_row;
  logic                   ot_valid;
  logic                   frame_done;
  logic signed [O_BW-1:0] ot_pool;

  stage2_act_quant #(
    .ACI_BW (ACI_BW),
    .B_BW   (B_BW),
    .O_BW   (O_BW),
    .SHIFT  (SHIFT)
  ) u_act_quant (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_clear     (i_clear),
    .i_bias      (i_bias),
    .i_in_valid  (bus.i_in_valid),
    .i_ci_acc    (bus.i_ci_acc),
    .o_act_valid (act_valid),
    .o_act       (act)
  );

  always_comb begin
    idx      = LW'(col >> 1);
    hmax     = (act > hold) ? act : hold;
    lb_rd    = linebuf[idx];
    last_col = (col == CW'(IMG_W - 1));
    last_row = (row == RW'(IMG_H - 1));
  end

  // Even rows park their horizontal maxima here for the odd row below.
  always_ff @(posedge clk) begin
    if (act_valid && !i_clear && col[0] && !row[0])
      linebuf[idx] <= hmax;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col        <= '0;
      row        <= '0;
      hold       <= '0;
      ot_valid   <= 1'b0;
      ot_pool    <= '0;
      frame_done <= 1'b0;
    end else if (i_clear) begin
      col        <= '0;
      row        <= '0;
      hold       <= '0;
      ot_valid   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      ot_valid   <= 1'b0;
      frame_done <= 1'b0;
      if (act_valid) begin
        if (!col[0]) begin
          hold <= act;
        end else if (row[0]) begin
          ot_pool    <= (lb_rd > hmax) ? lb_rd : hmax;
          ot_valid   <= 1'b1;
          frame_done <= last_col && last_row;
        end
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  assign bus.o_ot_valid   = ot_valid;
  assign bus.o_ot_pool    = ot_pool;
  assign bus.o_frame_done = frame_done;
endmodule

// File: tb/tb_stage2_bias_act_pool.sv
// Randomised bench for stage2_bias_act_pool against a frame-level pooling model.
module tb_stage2_bias_act_pool;
  import stage2_bias_act_pool_pkg::*;

  localparam int W  = ST2_IMG_W;
  localparam int H  = ST2_IMG_H;
  localparam int HI = 127;
`ifdef ST2_RELU_EN
  localparam int LO = 0;
`else
  localparam int LO = -128;
`endif

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               i_clear = 1'b0;
  logic signed [15:0] i_bias = '0;

  stage2_bias_act_pool_if #(.ACI_BW(ST2_ACI_BW), .O_BW(ST2_O_BW)) bus ();

  stage2_bias_act_pool #(
    .ACI_BW (ST2_ACI_BW), .B_BW (ST2_B_BW), .O_BW (ST2_O_BW),
    .SHIFT  (ST2_SHIFT),  .IMG_W (W),       .IMG_H (H)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (i_clear),
    .i_bias  (i_bias),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stray_done = 0;
  int bias_v = 0;
  int mn = 0;
  int pix [W*H];
  int win_acc [W*H];
  int exp_val[$], exp_cyc[$], got_val[$], got_cyc[$];
  bit exp_done[$], got_done[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.o_ot_valid) begin
      got_val.push_back(int'(bus.o_ot_pool));
      got_done.push_back(bus.o_frame_done);
      got_cyc.push_back(cyc);
    end else if (bus.o_frame_done) begin
      stray_done++;
    end
  end

  // Floor division by 2^SHIFT, then clamp to the output range.
  function automatic int act_ref(input int acc, input int b);
    int s, d, q;
    s = acc + b;
    d = 1 << ST2_SHIFT;
    if (s >= 0) q = s / d;
    else        q = -((-s + d - 1) / d);
    if (q > HI) q = HI;
    if (q < LO) q = LO;
    return q;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic int rnd_acc();
    return int'($urandom_range(0, 4000000)) - 2000000;
  endfunction

  task automatic model_push(input int acc);
    int r, c;
    pix[mn] = act_ref(acc, bias_v);
    r = mn / W;
    c = mn % W;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      exp_val.push_back(max4(pix[mn-W-1], pix[mn-W], pix[mn-1], pix[mn]));
      exp_done.push_back(mn == W*H - 1);
      exp_cyc.push_back(cyc + 3);
    end
    mn = (mn + 1) % (W*H);
  endtask

  task automatic send(input int acc);
    @(negedge clk);
    i_clear        = 1'b0;
    bus.i_in_valid = 1'b1;
    bus.i_ci_acc   = ST2_ACI_BW'(acc);
    model_push(acc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_clear        = 1'b0;
      bus.i_in_valid = 1'b0;
      bus.i_ci_acc   = ST2_ACI_BW'(rnd_acc());
    end
  endtask

  task automatic set_bias(input int b);
    bias_v = b;
    i_bias = 16'(b);
  endtask

  task automatic flush_queues();
    exp_val.delete(); exp_done.delete(); exp_cyc.delete();
    got_val.delete(); got_done.delete(); got_cyc.delete();
  endtask

  task automatic test_reset();
    bus.i_in_valid = 1'b0;
    bus.i_ci_acc   = '0;
    reset_n        = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.o_ot_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.o_ot_valid); end
    checks++; if (bus.o_ot_pool !== 8'sd0) begin errors++; $display("FAIL reset_pool: got %0d expected 0", bus.o_ot_pool); end
    checks++; if (bus.o_frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.o_frame_done); end
    reset_n = 1'b1;
    mn = 0;
    idle(2);
    flush_queues();
  endtask

  task automatic test_const_frame();
    int n;
    set_bias(0);
    for (int i = 0; i < W*H; i++) send(1280);
    idle(6);
    checks++; if (got_val.size() !== 16) begin errors++; $display("FAIL const_count: got %0d expected 16", got_val.size()); end
    n = (got_val.size() < exp_val.size()) ? got_val.size() : exp_val.size();
    for (int i = 0; i < n; i++) begin
      checks++; if (got_val[i] !== 5) begin errors++; $display("FAIL const_val[%0d]: got %0d expected 5", i, got_val[i]); end
      checks++; if (got_done[i] !== exp_done[i]) begin errors++; $display("FAIL const_done[%0d]: got %b expected %b", i, got_done[i], exp_done[i]); end
      checks++; if (got_cyc[i] !== exp_cyc[i]) begin errors++; $display("FAIL const_lat[%0d]: got cycle %0d expected %0d", i, got_cyc[i], exp_cyc[i]); end
    end
    checks++; if (stray_done !== 0) begin errors++; $display("FAIL const_stray_done: got %0d expected 0", stray_done); end
    flush_queues();
  endtask

  task automatic test_clamp();
    int vals [3];
    int need [3];
    int n;
    vals[0] = -2560;  need[0] = (LO == 0) ? 0 : -10;
    vals[1] = 100000; need[1] = 127;
    vals[2] = -100000; need[2] = (LO == 0) ? 0 : -128;
    set_bias(0);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < W*H; i++) send(vals[k]);
      idle(6);
      checks++; if (got_val.size() !== exp_val.size()) begin errors++; $display("FAIL clamp_count[%0d]: got %0d expected %0d", vals[k], got_val.size(), exp_val.size()); end
      n = (got_val.size() < exp_val.size()) ? got_val.size() : exp_val.size();
      for (int i = 0; i < n; i++) begin
        checks++; if (got_val[i] !== need[k]) begin errors++; $display("FAIL clamp_val[%0d][%0d]: got %0d expected %0d", vals[k], i, got_val[i], need[k]); end
        checks++; if (got_val[i] !== exp_val[i]) begin errors++; $display("FAIL clamp_model[%0d][%0d]: got %0d expected %0d", vals[k], i, got_val[i], exp_val[i]); end
        checks++; if (got_done[i] !== exp_done[i]) begin errors++; $display("FAIL clamp_done[%0d][%0d]: got %b expected %b", vals[k], i, got_done[i], exp_done[i]); end
      end
      flush_queues();
    end
  endtask

  task automatic test_window(input int gap);
    int n;
    set_bias(-256);
    for (int i = 0; i < W*H; i++) begin
      send(win_acc[i]);
      if (gap > 0) idle(gap);
    end
    idle(6);
    checks++; if (got_val.size() !== 16) begin errors++; $display("FAIL win%0d_count: got %0d expected 16", gap, got_val.size()); end
    if (got_val.size() > 0) begin
      checks++; if (got_val[0] !== 3) begin errors++; $display("FAIL win%0d_first: got %0d expected 3", gap, got_val[0]); end
    end
    n = (got_val.size() < exp_val.size()) ? got_val.size() : exp_val.size();
    for (int i = 0; i < n; i++) begin
      checks++; if (got_val[i] !== exp_val[i]) begin errors++; $display("FAIL win%0d_val[%0d]: got %0d expected %0d", gap, i, got_val[i], exp_val[i]); end
      checks++; if (got_done[i] !== exp_done[i]) begin errors++; $display("FAIL win%0d_done[%0d]: got %b expected %b", gap, i, got_done[i], exp_done[i]); end
      checks++; if (got_cyc[i] !== exp_cyc[i]) begin errors++; $display("FAIL win%0d_lat[%0d]: got cycle %0d expected %0d", gap, i, got_cyc[i], exp_cyc[i]); end
    end
    flush_queues();
  endtask

  task automatic test_clear();
    int n, dones;
    set_bias(int'($urandom_range(0, 2000)) - 1000);
    for (int i = 0; i < 20; i++) send(rnd_acc());
    // Clear coincides with a valid sample: that sample must vanish.
    @(negedge clk);
    i_clear = 1'b1; bus.i_in_valid = 1'b1; bus.i_ci_acc = ST2_ACI_BW'(rnd_acc());
    mn = 0;
    for (int i = 0; i < W*H; i++) send(rnd_acc());
    for (int i = 0; i < 16; i++) send(rnd_acc());
    @(negedge clk);
    i_clear = 1'b1; bus.i_in_valid = 1'b0;
    // The window closed by the sample just before clear is still in flight.
    void'(exp_val.pop_back()); void'(exp_done.pop_back()); void'(exp_cyc.pop_back());
    mn = 0;
    for (int i = 0; i < W*H; i++) send(rnd_acc());
    idle(6);
    checks++; if (got_val.size() !== 4 + 16 + 3 + 16) begin errors++; $display("FAIL clear_count: got %0d expected %0d", got_val.size(), 4 + 16 + 3 + 16); end
    n = (got_val.size() < exp_val.size()) ? got_val.size() : exp_val.size();
    dones = 0;
    for (int i = 0; i < n; i++) begin
      if (got_done[i]) dones++;
      checks++; if (got_val[i] !== exp_val[i]) begin errors++; $display("FAIL clear_val[%0d]: got %0d expected %0d", i, got_val[i], exp_val[i]); end
      checks++; if (got_done[i] !== exp_done[i]) begin errors++; $display("FAIL clear_done[%0d]: got %b expected %b", i, got_done[i], exp_done[i]); end
      checks++; if (got_cyc[i] !== exp_cyc[i]) begin errors++; $display("FAIL clear_lat[%0d]: got cycle %0d expected %0d", i, got_cyc[i], exp_cyc[i]); end
    end
    checks++; if (dones !== 2) begin errors++; $display("FAIL clear_done_total: got %0d expected 2", dones); end
    flush_queues();
  endtask

  task automatic test_reset_midframe();
    int n;
    set_bias(int'($urandom_range(0, 2000)) - 1000);
    for (int i = 0; i < 30; i++) send(rnd_acc());
    idle(5);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.o_ot_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", bus.o_ot_valid); end
    checks++; if (bus.o_ot_pool !== 8'sd0) begin errors++; $display("FAIL midreset_pool: got %0d expected 0", bus.o_ot_pool); end
    reset_n = 1'b1;
    mn = 0;
    for (int i = 0; i < W*H; i++) send(rnd_acc());
    idle(6);
    checks++; if (got_val.size() !== 7 + 16) begin errors++; $display("FAIL midreset_count: got %0d expected 23", got_val.size()); end
    n = (got_val.size() < exp_val.size()) ? got_val.size() : exp_val.size();
    for (int i = 0; i < n; i++) begin
      checks++; if (got_val[i] !== exp_val[i]) begin errors++; $display("FAIL midreset_val[%0d]: got %0d expected %0d", i, got_val[i], exp_val[i]); end
      checks++; if (got_done[i] !== exp_done[i]) begin errors++; $display("FAIL midreset_done[%0d]: got %b expected %b", i, got_done[i], exp_done[i]); end
    end
    checks++; if (stray_done !== 0) begin errors++; $display("FAIL stray_done: got %0d expected 0", stray_done); end
    flush_queues();
  endtask

  initial begin
    for (int i = 0; i < W*H; i++) win_acc[i] = rnd_acc();
    win_acc[0]     = 256;
    win_acc[1]     = 512;
    win_acc[W]     = 768;
    win_acc[W + 1] = 1024;
    test_reset();
    test_const_frame();
    test_clamp();
    test_window(0);
    test_window(2);
    test_clear();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
